// File: rtl/cl_sde_result_rx.sv
// SDE classification stream receiver: sequential argmax over ten signed 16-bit
// scores per beat, result records queued in a FIFO and popped through cfg reads.
module cl_sde_result_rx #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ots_valid,
  input  logic [511:0] ots_data,
  input  logic [63:0]  ots_keep,
  input  logic         ots_last,
  output logic         ots_ready,
  input  logic [11:0]  cfg_addr,
  input  logic         cfg_wr,
  input  logic         cfg_rd,
  input  logic [31:0]  cfg_wdata,
  output logic         cfg_ack,
  output logic [31:0]  cfg_rdata,
  output logic         res_avail
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [159:0]        beat;
  logic [3:0]          k;
  logic [3:0]          best_idx;
  logic signed [15:0]  best;
  logic signed [15:0]  score_k;
  logic [10:0]         seq;
  logic [10:0]         seq_cnt;
  logic [31:0]         words_cnt;
  logic [31:0]         err_cnt;
  logic                enable;

  logic [31:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                full, empty;

  logic                accept, push, pop, ctrl_wr, clear, bad_fmt;
  logic [31:0]         record;
  logic [31:0]         rd_val;
  logic                unused_bits;

  assign unused_bits = ^{ots_data[511:160], ots_keep[63:20], cfg_wdata[31:2]};

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign res_avail = ~empty;
  assign ots_ready = (state == IDLE) & enable & ~full;

  assign accept  = ots_valid & ots_ready;
  assign push    = (state == PUSH);
  assign pop     = cfg_rd & (cfg_addr == 12'h008) & ~empty;
  assign ctrl_wr = cfg_wr & (cfg_addr == 12'h000);
  assign clear   = ctrl_wr & cfg_wdata[1];
  assign bad_fmt = (ots_keep[19:0] != 20'hFFFFF) | ~ots_last;

  assign score_k = beat[{k, 4'b0000} +: 16];
  assign record  = {1'b1, seq, best_idx, best};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (k == 4'd9) state_nxt = PUSH;
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      k        <= '0;
      best_idx <= '0;
      best     <= '0;
      seq      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        beat     <= ots_data[159:0];
        best     <= ots_data[15:0];
        best_idx <= '0;
        k        <= 4'd1;
        seq      <= clear ? '0 : seq_cnt;
      end else if (state == SCAN) begin
        if (score_k > best) begin
          best     <= score_k;
          best_idx <= k;
        end
        k <= k + 4'd1;
      end
    end
  end

  // Clear has priority over the increments of a beat accepted on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_cnt   <= '0;
      words_cnt <= '0;
      err_cnt   <= '0;
      enable    <= 1'b0;
    end else begin
      if (clear) begin
        seq_cnt   <= '0;
        words_cnt <= '0;
        err_cnt   <= '0;
      end else if (accept) begin
        seq_cnt <= seq_cnt + 11'd1;
        if (words_cnt != '1) words_cnt <= words_cnt + 32'd1;
        if (bad_fmt && (err_cnt != '1)) err_cnt <= err_cnt + 32'd1;
      end
      if (ctrl_wr) enable <= cfg_wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= record;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (cfg_addr)
      12'h000: rd_val = {31'd0, enable};
      12'h004: rd_val = {18'd0, state, 1'b0, empty, full, 9'(count)};
      12'h008: rd_val = empty ? '0 : mem[rd_ptr];
      12'h00C: rd_val = words_cnt;
      12'h010: rd_val = err_cnt;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ack   <= 1'b0;
      cfg_rdata <= '0;
    end else begin
      cfg_ack   <= cfg_rd | cfg_wr;
      cfg_rdata <= cfg_rd ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_cl_sde_result_rx.sv
// Randomized bench for cl_sde_result_rx against a transaction-level model of the
// receiver (argmax per beat, record queue, counters, register reads).
module tb_cl_sde_result_rx;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ots_valid;
  logic [511:0] ots_data;
  logic [63:0]  ots_keep;
  logic         ots_last;
  logic         ots_ready;
  logic [11:0]  cfg_addr;
  logic         cfg_wr;
  logic         cfg_rd;
  logic [31:0]  cfg_wdata;
  logic         cfg_ack;
  logic [31:0]  cfg_rdata;
  logic         res_avail;

  int checks = 0;
  int errors = 0;

  cl_sde_result_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ots_valid(ots_valid), .ots_data(ots_data), .ots_keep(ots_keep),
    .ots_last(ots_last), .ots_ready(ots_ready),
    .cfg_addr(cfg_addr), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
    .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
    .res_avail(res_avail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_q[$];
  logic        m_en = 1'b0;
  logic        m_busy = 1'b0;
  logic [10:0] m_seq = '0;
  logic [31:0] m_words = '0;
  logic [31:0] m_err = '0;
  logic [31:0] m_rec = '0;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;
  int          m_cyc = 0;
  int          m_acc_cyc = 0;
  int          m_acc_count = 0;

  function automatic logic [31:0] make_rec(input logic [159:0] d, input logic [10:0] s);
    int bi = 0;
    int bv = $signed(d[15:0]);
    for (int i = 1; i < 10; i++) begin
      int v = $signed(d[16*i +: 16]);
      if (v > bv) begin
        bv = v;
        bi = i;
      end
    end
    return {1'b1, s, 4'(bi), 16'(bv)};
  endfunction

  function automatic logic m_ready_now();
    return m_en && !m_busy && (m_q.size() < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic rdy, acc, pop, push, clr, ctrl_wr;
    logic [1:0]  st;
    logic [10:0] s;
    logic [31:0] rv;
    int d;
    if (rst) begin
      m_q.delete();
      m_en = 0; m_busy = 0; m_seq = '0; m_words = '0; m_err = '0;
      m_ack = 0; m_rdata = '0;
    end else begin
      m_cyc++;
      d       = m_cyc - m_acc_cyc;
      st      = !m_busy ? 2'd0 : (d <= 9 ? 2'd1 : 2'd2);
      rdy     = m_ready_now();
      acc     = ots_valid && rdy;
      push    = m_busy && (d == 10);
      pop     = cfg_rd && (cfg_addr == 12'h008) && (m_q.size() > 0);
      ctrl_wr = cfg_wr && (cfg_addr == 12'h000);
      clr     = ctrl_wr && cfg_wdata[1];
      rv = '0;
      if (cfg_rd) begin
        case (cfg_addr)
          12'h000: rv = {31'd0, m_en};
          12'h004: rv = {18'd0, st, 1'b0, m_q.size() == 0, m_q.size() == DEPTH, 9'(m_q.size())};
          12'h008: rv = (m_q.size() > 0) ? m_q[0] : '0;
          12'h00C: rv = m_words;
          12'h010: rv = m_err;
          default: rv = '0;
        endcase
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_rec);
        m_busy = 0;
      end
      if (acc) begin
        s = clr ? 11'd0 : m_seq;
        m_rec = make_rec(ots_data[159:0], s);
        m_busy = 1;
        m_acc_cyc = m_cyc;
        m_acc_count++;
        m_seq = m_seq + 11'd1;
        if (m_words != 32'hFFFF_FFFF) m_words++;
        if (((ots_keep[19:0] != 20'hFFFFF) || !ots_last) && m_err != 32'hFFFF_FFFF) m_err++;
      end
      if (clr) begin
        m_seq = '0; m_words = '0; m_err = '0;
      end
      if (ctrl_wr) m_en = cfg_wdata[0];
      m_ack   = cfg_rd || cfg_wr;
      m_rdata = rv;
    end
  end

  always @(negedge clk) begin
    chk("ots_ready", 32'(ots_ready), 32'(m_ready_now()));
    chk("res_avail", 32'(res_avail), 32'(m_q.size() > 0));
    chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    if (m_ack || rst) chk("cfg_rdata", cfg_rdata, m_rdata);
  end

  // ---------------- stimulus ----------------
  logic signed [15:0] sc [10];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_data();
    for (int i = 0; i < 16; i++) ots_data[32*i +: 32] = $urandom;
    for (int i = 0; i < 10; i++) ots_data[16*i +: 16] = sc[i];
  endtask

  task automatic rand_scores();
    for (int i = 0; i < 10; i++)
      sc[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8)) - 16'sd4;
  endtask

  task automatic cfg_write(input logic [11:0] a, input logic [31:0] v);
    cfg_addr = a; cfg_wdata = v; cfg_wr = 1;
    step(1);
    cfg_wr = 0;
  endtask

  task automatic cfg_read(input logic [11:0] a, output logic [31:0] v);
    cfg_addr = a; cfg_rd = 1;
    step(1);
    cfg_rd = 0;
    v = cfg_rdata;
  endtask

  task automatic send_beat(input logic [19:0] keep, input logic last);
    int c0 = m_acc_count;
    int g = 0;
    fill_data();
    ots_keep = {44'd0, keep}; ots_last = last; ots_valid = 1;
    while (m_acc_count == c0 && g < 300) begin
      step(1);
      g++;
    end
    ots_valid = 0;
    chk("accept_timeout", 32'(m_acc_count != c0), 32'd1);
  endtask

  task automatic drain(output logic [31:0] last_rec);
    logic [31:0] v;
    int g = 0;
    last_rec = '0;
    do begin
      cfg_read(12'h008, v);
      if (v != 0) last_rec = v;
      g++;
    end while (v != 0 && g < 20);
    chk("drain_timeout", 32'(g < 20), 32'd1);
  endtask

  initial begin
    logic [31:0] v, last;
    int base, g;
    rst = 1; ots_valid = 0; ots_data = '0; ots_keep = '0; ots_last = 0;
    cfg_addr = '0; cfg_wr = 0; cfg_rd = 0; cfg_wdata = '0;
    step(3);
    chk("reset_ready", 32'(ots_ready), 32'd0);
    chk("reset_avail", 32'(res_avail), 32'd0);
    chk("reset_rdata", cfg_rdata, 32'd0);
    rst = 0;
    step(1);

    // basic argmax with tie
    cfg_write(12'h000, 32'h1);
    sc = '{16'sd5, -16'sd3, 16'sd7, 16'sd7, 16'sd2, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1};
    send_beat(20'hFFFFF, 1);
    step(12);
    cfg_read(12'h008, v); chk("basic_rec", v, 32'h8002_0007);
    cfg_read(12'h00C, v); chk("basic_words", v, 32'd1);
    cfg_read(12'h010, v); chk("basic_err", v, 32'd0);

    // all negative, signed compare
    for (int i = 0; i < 9; i++) sc[i] = -16'sd1;
    sc[9] = 16'sh8000;
    send_beat(20'hFFFFF, 1);
    step(12);
    cfg_read(12'h008, v); chk("neg_rec", v, 32'h8010_FFFF);

    // format error still pushes
    for (int i = 0; i < 10; i++) sc[i] = 16'sd0;
    send_beat(20'h0FFFF, 0);
    step(12);
    cfg_read(12'h010, v); chk("fmt_err", v, 32'd1);
    cfg_read(12'h008, v); chk("fmt_rec", v, 32'h8020_0000);

    // backpressure
    base = m_acc_count;
    rand_scores(); fill_data();
    ots_keep = {44'd0, 20'hFFFFF}; ots_last = 1; ots_valid = 1;
    step(60);
    cfg_read(12'h004, v); chk("bp_status", v, 32'h0000_0204);
    for (int i = 0; i < 4; i++) begin
      cfg_read(12'h008, v);
      chk("bp_seq", 32'(v[30:20]), 32'(3 + i));
    end
    g = 0;
    while (m_acc_count - base < 6 && g < 100) begin step(1); g++; end
    ots_valid = 0;
    chk("bp_resume", 32'(m_acc_count - base), 32'd6);
    step(15);
    drain(last);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rand_scores(); fill_data();
      ots_valid = ($urandom_range(0, 9) < 7);
      ots_keep  = {44'($urandom), ($urandom_range(0, 9) == 0) ? 20'($urandom) : 20'hFFFFF};
      ots_last  = ($urandom_range(0, 9) != 0);
      cfg_rd = 0; cfg_wr = 0;
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5: begin cfg_rd = 1; cfg_addr = 12'h008; end
        6:  begin cfg_rd = 1; cfg_addr = 12'h000; end
        7:  begin cfg_rd = 1; cfg_addr = 12'h004; end
        8:  begin cfg_rd = 1; cfg_addr = 12'h00C; end
        9:  begin cfg_rd = 1; cfg_addr = 12'h010; end
        10: begin cfg_rd = 1; cfg_addr = 12'h020; end
        11: begin
          cfg_wr = 1; cfg_addr = 12'h000;
          cfg_wdata = {$urandom_range(0, 7) == 0 ? 30'($urandom) : 30'd0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0};
        end
        12: begin cfg_wr = 1; cfg_addr = 12'h008; cfg_wdata = $urandom; end
        default: ;
      endcase
      step(1);
    end
    ots_valid = 0; cfg_rd = 0; cfg_wr = 0;
    step(15);
    drain(last);

    // seq wrap over 2049 beats
    cfg_write(12'h000, 32'h3);
    base = m_acc_count; g = 0;
    ots_valid = 1; ots_keep = {44'd0, 20'hFFFFF}; ots_last = 1;
    while (m_acc_count - base < 2049 && g < 40000) begin
      step(1);
      g++;
      if (m_acc_count - base >= 2049) ots_valid = 0;
      cfg_addr = 12'h008;
      cfg_rd = !cfg_rd && (m_q.size() > 0);
      if (ots_valid) begin rand_scores(); fill_data(); end
    end
    ots_valid = 0; cfg_rd = 0;
    chk("wrap_count", 32'(m_acc_count - base), 32'd2049);
    step(15);
    cfg_read(12'h00C, v); chk("wrap_words", v, 32'd2049);
    drain(last);
    chk("wrap_last_seq", 32'(last[30:20]), 32'd0);
    chk("wrap_last_valid", 32'(last[31]), 32'd1);
    cfg_write(12'h000, 32'h3);
    cfg_read(12'h00C, v); chk("clr_words", v, 32'd0);
    cfg_read(12'h010, v); chk("clr_err", v, 32'd0);
    rand_scores();
    send_beat(20'hFFFFF, 1);
    step(12);
    cfg_read(12'h008, v); chk("clr_seq", 32'(v[30:20]), 32'd0);

    // reset mid-SCAN
    rand_scores();
    send_beat(20'hFFFFF, 1);
    step(3);
    rst = 1;
    step(2);
    rst = 0;
    chk("rst_ready", 32'(ots_ready), 32'd0);
    chk("rst_avail", 32'(res_avail), 32'd0);
    step(20);
    chk("rst_no_rec", 32'(res_avail), 32'd0);
    cfg_read(12'h004, v); chk("rst_status", v, 32'h0000_0400);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
